// File: rtl/perf_counter_unit.sv
// perf_counter_unit: saturating pipeline event counters, sticky overflow status,
// and a snapshot shadow bank read through a registered port (index NCNT = status).
module perf_counter_unit #(
    parameter int W    = 32,
    parameter int NCNT = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  InstrE,
    input  logic         StallD,
    input  logic         StallE,
    input  logic         StalluOp,
    input  logic         FlushD,
    input  logic         FlushE,
    input  logic         IStall,
    input  logic         DStall,
    input  logic         ldrStallD,
    input  logic         PCSrcW,
    input  logic         PCWrPendingF,
    input  logic         BranchE,
    input  logic         BranchTakenE,
    input  logic         CountEn,
    input  logic         Clear,
    input  logic         Snapshot,
    input  logic [3:0]   RdAddr,
    output logic [W-1:0] RdData
);
    localparam logic [W-1:0] MaxVal = '1;

    logic [W-1:0]    cnt [NCNT];
    logic [W-1:0]    shadow [NCNT+1];
    logic [NCNT-1:0] status;
    logic [W-1:0]    runLen, runNext;
    logic [31:0]     oldInstrE;
    logic            oldIStall, oldDStall, oldLdrStallD, oldPCSrcW, oldPCWrPendingF;
    logic            newInstr;
    logic [NCNT-1:0] ev;
    logic [W-1:0]    statusWord;

    assign newInstr   = (InstrE != oldInstrE) && (InstrE != '0);
    assign statusWord = W'(status);
    assign runNext    = DStall ? ((runLen == MaxVal) ? runLen : runLen + W'(1)) : '0;
    // Bit 14 (longest DStall run) is handled separately from the plain increments.
    assign ev = {DStall, FlushE, FlushD,
                 PCWrPendingF & ~oldPCWrPendingF, PCSrcW & ~oldPCSrcW, ldrStallD & ~oldLdrStallD,
                 DStall, DStall & ~oldDStall, IStall & ~oldIStall,
                 newInstr & BranchTakenE, newInstr & BranchE, StallD & ~StalluOp,
                 (InstrE == '0) | StallE, newInstr, 1'b1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
            for (int i = 0; i <= NCNT; i++) shadow[i] <= '0;
            status          <= '0;
            runLen          <= '0;
            RdData          <= '0;
            oldInstrE       <= '0;
            oldIStall       <= 1'b0;
            oldDStall       <= 1'b0;
            oldLdrStallD    <= 1'b0;
            oldPCSrcW       <= 1'b0;
            oldPCWrPendingF <= 1'b0;
        end else begin
            // History registers track the pipeline even while counting is paused.
            oldInstrE       <= InstrE;
            oldIStall       <= IStall;
            oldDStall       <= DStall;
            oldLdrStallD    <= ldrStallD;
            oldPCSrcW       <= PCSrcW;
            oldPCWrPendingF <= PCWrPendingF;
            RdData          <= shadow[RdAddr];
            if (Snapshot) begin
                for (int i = 0; i < NCNT; i++) shadow[i] <= cnt[i];
                shadow[NCNT] <= statusWord;
            end
            if (Clear) begin
                for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
                status <= '0;
                runLen <= '0;
            end else if (CountEn) begin
                runLen <= runNext;
                for (int i = 0; i < NCNT-1; i++) begin
                    if (ev[i]) begin
                        if (cnt[i] == MaxVal) status[i] <= 1'b1;
                        else cnt[i] <= cnt[i] + W'(1);
                    end
                end
                if (runNext > cnt[NCNT-1]) cnt[NCNT-1] <= runNext;
                if (ev[NCNT-1] && cnt[NCNT-1] == MaxVal) status[NCNT-1] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_perf_counter_unit.sv
// tb_perf_counter_unit: drives W=32 and W=8 builds side by side and compares every
// read against an event-level reference model plus directed constant expectations.
module tb_perf_counter_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] InstrE = '0;
    logic        StallD = 0, StallE = 0, StalluOp = 0, FlushD = 0, FlushE = 0, IStall = 0, DStall = 0;
    logic        ldrStallD = 0, PCSrcW = 0, PCWrPendingF = 0, BranchE = 0, BranchTakenE = 0;
    logic        CountEn = 0, Clear = 0, Snapshot = 0;
    logic [3:0]  RdAddr = '0;
    logic [31:0] rdData32;
    logic [7:0]  rdData8;
    int          nChecks = 0, nFails = 0;

    always #5 clk = ~clk;

    perf_counter_unit #(.W(32)) dut32 (
        .clk(clk), .reset(reset), .InstrE(InstrE), .StallD(StallD), .StallE(StallE),
        .StalluOp(StalluOp), .FlushD(FlushD), .FlushE(FlushE), .IStall(IStall), .DStall(DStall),
        .ldrStallD(ldrStallD), .PCSrcW(PCSrcW), .PCWrPendingF(PCWrPendingF), .BranchE(BranchE),
        .BranchTakenE(BranchTakenE), .CountEn(CountEn), .Clear(Clear), .Snapshot(Snapshot),
        .RdAddr(RdAddr), .RdData(rdData32));

    perf_counter_unit #(.W(8)) dut8 (
        .clk(clk), .reset(reset), .InstrE(InstrE), .StallD(StallD), .StallE(StallE),
        .StalluOp(StalluOp), .FlushD(FlushD), .FlushE(FlushE), .IStall(IStall), .DStall(DStall),
        .ldrStallD(ldrStallD), .PCSrcW(PCSrcW), .PCWrPendingF(PCWrPendingF), .BranchE(BranchE),
        .BranchTakenE(BranchTakenE), .CountEn(CountEn), .Clear(Clear), .Snapshot(Snapshot),
        .RdAddr(RdAddr), .RdData(rdData8));

    // Reference model: index 0 models the 32-bit build, index 1 the 8-bit build.
    longint      mCnt [2][15];
    longint      mShadow [2][16];
    longint      mRun [2];
    longint      mStatus [2];
    longint      mExpRd [2];
    longint      maxVal [2];
    logic [31:0] mOldInstr;
    bit          mOldI, mOldD, mOldL, mOldP, mOldF;

    function automatic void modelReset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 15; i++) mCnt[k][i] = 0;
            for (int i = 0; i < 16; i++) mShadow[k][i] = 0;
            mRun[k] = 0;
            mStatus[k] = 0;
            mExpRd[k] = 0;
        end
        mOldInstr = '0;
        {mOldI, mOldD, mOldL, mOldP, mOldF} = '0;
    endfunction

    function automatic void modelStep();
        bit newI;
        bit ev [15];
        newI = (InstrE != mOldInstr) && (InstrE != 0);
        ev = '{1'b1, newI, (InstrE == 0) || StallE, StallD && !StalluOp, newI && BranchE,
               newI && BranchTakenE, IStall && !mOldI, DStall && !mOldD, DStall,
               ldrStallD && !mOldL, PCSrcW && !mOldP, PCWrPendingF && !mOldF, FlushD, FlushE, DStall};
        for (int k = 0; k < 2; k++) begin
            mExpRd[k] = mShadow[k][RdAddr];
            if (Snapshot) begin
                for (int i = 0; i < 15; i++) mShadow[k][i] = mCnt[k][i];
                mShadow[k][15] = mStatus[k] & maxVal[k];
            end
            if (Clear) begin
                for (int i = 0; i < 15; i++) mCnt[k][i] = 0;
                mRun[k] = 0;
                mStatus[k] = 0;
            end else if (CountEn) begin
                for (int i = 0; i < 14; i++)
                    if (ev[i]) begin
                        if (mCnt[k][i] == maxVal[k]) mStatus[k] |= longint'(1) << i;
                        else mCnt[k][i]++;
                    end
                if (DStall) begin
                    if (mCnt[k][14] == maxVal[k]) mStatus[k] |= longint'(1) << 14;
                    if (mRun[k] < maxVal[k]) mRun[k]++;
                    if (mRun[k] > mCnt[k][14]) mCnt[k][14] = mRun[k];
                end else mRun[k] = 0;
            end
        end
        mOldInstr = InstrE;
        {mOldI, mOldD, mOldL, mOldP, mOldF} = {IStall, DStall, ldrStallD, PCSrcW, PCWrPendingF};
    endfunction

    task automatic check(string name, longint got, longint exp);
        nChecks++;
        if (got != exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        modelStep();
        @(posedge clk);
        #1;
        check("rd32_model", rdData32, mExpRd[0]);
        check("rd8_model", rdData8, mExpRd[1]);
    endtask

    task automatic idle();
        InstrE = '0;
        {StallD, StallE, StalluOp, FlushD, FlushE, IStall, DStall, ldrStallD} = '0;
        {PCSrcW, PCWrPendingF, BranchE, BranchTakenE, Clear, Snapshot} = '0;
    endtask

    task automatic expectShadow(int a, longint e32, longint e8);
        RdAddr = 4'(a);
        step();
        check($sformatf("shadow%0d_w32", a), rdData32, e32);
        check($sformatf("shadow%0d_w8", a), rdData8, e8);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    typedef struct {
        logic [31:0] instr;
        bit br, ds, pc, en;
    } vec_t;
    typedef struct {
        int     addr;
        longint exp;
    } chk_t;

    vec_t vecs [22];
    chk_t chks [12];

    initial begin
        maxVal[0] = 64'hFFFF_FFFF;
        maxVal[1] = 255;
        modelReset();
        vecs = '{'{32'h1111, 0, 0, 0, 1}, '{32'h1111, 0, 0, 0, 1}, '{32'h2222, 1, 0, 0, 1},
                 '{32'h0, 0, 0, 0, 1}, '{32'h2222, 1, 0, 0, 1},
                 '{0, 0, 1, 0, 1}, '{0, 0, 1, 0, 1}, '{0, 0, 1, 0, 1}, '{0, 0, 0, 0, 1}, '{0, 0, 0, 0, 1},
                 '{0, 0, 1, 0, 1}, '{0, 0, 1, 0, 1}, '{0, 0, 1, 0, 1}, '{0, 0, 1, 0, 1}, '{0, 0, 1, 0, 1},
                 '{0, 0, 0, 1, 0}, '{0, 0, 0, 1, 0}, '{0, 0, 0, 1, 1}, '{0, 0, 0, 1, 1},
                 '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}};
        chks = '{'{0, 28}, '{1, 3}, '{2, 24}, '{3, 0}, '{4, 2}, '{5, 0},
                 '{7, 2}, '{8, 8}, '{10, 0}, '{11, 0}, '{14, 5}, '{15, 0}};

        #1;
        check("reset_rd32", rdData32, 0);
        check("reset_rd8", rdData8, 0);
        #11 reset = 1'b1;

        CountEn = 1'b1;
        run(10);
        Snapshot = 1'b1;
        step();
        Snapshot = 1'b0;
        CountEn = 1'b0;
        expectShadow(0, 10, 10);
        expectShadow(1, 0, 0);
        expectShadow(2, 10, 10);

        for (int i = 0; i < 22; i++) begin
            InstrE = vecs[i].instr;
            BranchE = vecs[i].br;
            DStall = vecs[i].ds;
            PCSrcW = vecs[i].pc;
            CountEn = vecs[i].en;
            step();
        end
        idle();
        CountEn = 1'b0;
        Snapshot = 1'b1;
        step();
        Snapshot = 1'b0;
        for (int i = 0; i < 12; i++) expectShadow(chks[i].addr, chks[i].exp, chks[i].exp);

        Clear = 1'b1;
        CountEn = 1'b1;
        step();
        Clear = 1'b0;
        run(300);
        CountEn = 1'b0;
        Snapshot = 1'b1;
        step();
        Snapshot = 1'b0;
        expectShadow(0, 300, 255);
        expectShadow(2, 300, 255);
        expectShadow(15, 0, 5);
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        Snapshot = 1'b1;
        step();
        Snapshot = 1'b0;
        expectShadow(15, 0, 0);
        expectShadow(0, 0, 0);

        CountEn = 1'b1;
        run(50);
        Snapshot = 1'b1;
        Clear = 1'b1;
        step();
        {Snapshot, Clear, CountEn} = '0;
        expectShadow(0, 50, 50);
        CountEn = 1'b1;
        run(4);
        CountEn = 1'b0;
        Snapshot = 1'b1;
        step();
        Snapshot = 1'b0;
        expectShadow(0, 4, 4);
        expectShadow(2, 4, 4);

        for (int n = 0; n < 3000; n++) begin
            InstrE = 32'($urandom_range(0, 3));
            StallD = $urandom_range(0, 2) == 0;
            StallE = $urandom_range(0, 3) == 0;
            StalluOp = $urandom_range(0, 1) == 0;
            FlushD = $urandom_range(0, 4) == 0;
            FlushE = $urandom_range(0, 4) == 0;
            if ($urandom_range(0, 2) == 0) IStall = ~IStall;
            if ($urandom_range(0, 3) == 0) DStall = ~DStall;
            if ($urandom_range(0, 2) == 0) ldrStallD = ~ldrStallD;
            if ($urandom_range(0, 2) == 0) PCSrcW = ~PCSrcW;
            if ($urandom_range(0, 2) == 0) PCWrPendingF = ~PCWrPendingF;
            BranchE = $urandom_range(0, 1) == 0;
            BranchTakenE = BranchE && ($urandom_range(0, 1) == 0);
            CountEn = $urandom_range(0, 7) != 0;
            Snapshot = $urandom_range(0, 7) == 0;
            Clear = $urandom_range(0, 399) == 0;
            RdAddr = 4'($urandom_range(0, 15));
            step();
        end

        #2 reset = 1'b0;
        #1;
        check("midreset_rd32", rdData32, 0);
        check("midreset_rd8", rdData8, 0);
        modelReset();
        idle();
        CountEn = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int a = 0; a < 16; a++) expectShadow(a, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
